// File: rtl/vga_frame_writer.sv
// Captures one vsync-delimited frame from a pixel stream into the frame-buffer RAM.
// Supports single-shot or continuous capture and flags frames of the wrong size.
module vga_frame_writer #(
    parameter int   DATA_WIDTH = 8,
    parameter int   RAM_DEPTH  = 640*480,
    parameter int   ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter logic VS_POL     = 1'b0
) (
    input  logic                  clk_i_fw,
    input  logic                  rstn_i_fw,
    input  logic                  en_i_fw,
    input  logic                  cont_i_fw,
    input  logic                  p_tick_i_fw,
    input  logic                  vsync_i_fw,
    input  logic                  de_i_fw,
    input  logic [DATA_WIDTH-1:0] pix_i_fw,
    output logic                  en_o_fw,
    output logic                  we_o_fw,
    output logic [ADDR_WIDTH-1:0] addr_o_fw,
    output logic [DATA_WIDTH-1:0] data_o_fw,
    output logic                  busy_o_fw,
    output logic                  frame_done_o_fw,
    output logic                  overrun_o_fw,
    output logic                  underrun_o_fw
);

    // The counter must be able to hold RAM_DEPTH itself to tell "full" from "overflowing".
    localparam int               CNT_W   = $clog2(RAM_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAM_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;
    logic                    vs_q;
    logic                    en_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    ovr_q;
    logic                    und_q;
    logic                    vs_start;
    logic                    pix_acc;

    assign vs_start = (vsync_i_fw == VS_POL) && (vs_q != VS_POL);
    assign pix_acc  = p_tick_i_fw && de_i_fw && !vs_start;
    assign cnt_d    = cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i_fw) begin
        if (!rstn_i_fw) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vs_q    <= ~VS_POL;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below sees
            // the register values from before this edge regardless of statement order.
            vs_q   <= vsync_i_fw;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_i_fw) begin
                        ovr_q   <= 1'b0;
                        und_q   <= 1'b0;
                        en_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_VS;
                    end
                end
                WAIT_VS: begin
                    if (vs_start) begin
                        cnt_q   <= '0;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vs_start) begin
                        done_q <= 1'b1;
                        cnt_q  <= '0;
                        if (cnt_q != DEPTH_C) und_q <= 1'b1;
                        if (!cont_i_fw) begin
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (pix_acc) begin
                        if (cnt_q < DEPTH_C) begin
                            we_q   <= 1'b1;
                            addr_q <= cnt_q[ADDR_WIDTH-1:0];
                            data_q <= pix_i_fw;
                            cnt_q  <= cnt_d;
                        end else begin
                            // Counter saturates: surplus pixels are dropped, never wrapped.
                            ovr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_o_fw         = en_q;
    assign we_o_fw         = we_q;
    assign addr_o_fw       = addr_q;
    assign data_o_fw       = data_q;
    assign busy_o_fw       = busy_q;
    assign frame_done_o_fw = done_q;
    assign overrun_o_fw    = ovr_q;
    assign underrun_o_fw   = und_q;

endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench for vga_frame_writer on a 4x4 frame with a pixel tick every 4 clks;
// RAM writes are logged at the falling edge and compared against hand-computed frames.
module tb_vga_frame_writer;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rstn, en, cont, p_tick, vsync, de;
    logic [DW-1:0] pix;
    logic          en_o, we_o, busy_o, done_o, ovr_o, und_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;

    vga_frame_writer #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .VS_POL(1'b0)) dut (
        .clk_i_fw(clk), .rstn_i_fw(rstn), .en_i_fw(en), .cont_i_fw(cont),
        .p_tick_i_fw(p_tick), .vsync_i_fw(vsync), .de_i_fw(de), .pix_i_fw(pix),
        .en_o_fw(en_o), .we_o_fw(we_o), .addr_o_fw(addr_o), .data_o_fw(data_o),
        .busy_o_fw(busy_o), .frame_done_o_fw(done_o),
        .overrun_o_fw(ovr_o), .underrun_o_fw(und_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log and behavioural RAM, sampled on the falling edge.
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    logic [DW-1:0] ram[DEPTH];
    int            done_cnt = 0;
    int            bb_err   = 0;
    logic          prev_we  = 1'b0;

    always @(negedge clk) begin
        if (we_o) begin
            wr_addr.push_back(addr_o);
            wr_data.push_back(data_o);
            ram[addr_o] = data_o;
            if (prev_we) bb_err++;
        end
        if (done_o) done_cnt++;
        prev_we = we_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic send_pixel(input logic [DW-1:0] p);
        p_tick = 1'b1; de = 1'b1; pix = p;
        tick();
        p_tick = 1'b0; de = 1'b0;
        tick(3);
    endtask

    task automatic send_pixels(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) send_pixel(base + DW'(i));
    endtask

    task automatic vs_edge();
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(2);
    endtask

    task automatic arm();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic check_frame(input string name, input int start, input logic [DW-1:0] base,
                               input int n);
        for (int i = 0; i < n; i++) begin
            if (start + i < wr_addr.size()) begin
                check({name, "_addr"}, 32'(wr_addr[start+i]), 32'(i));
                check({name, "_data"}, 32'(wr_data[start+i]), 32'(base + DW'(i)));
            end
        end
    endtask

    typedef struct {
        logic          pt;
        logic          de;
        logic [DW-1:0] pix;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{pt: 1'b0, de: 1'b1, pix: 8'hA1, exp_we: 1'b0, exp_addr: 4'd0};
        vecs[1] = '{pt: 1'b1, de: 1'b0, pix: 8'hA2, exp_we: 1'b0, exp_addr: 4'd0};
        vecs[2] = '{pt: 1'b1, de: 1'b1, pix: 8'hA3, exp_we: 1'b1, exp_addr: 4'd0};
        vecs[3] = '{pt: 1'b0, de: 1'b0, pix: 8'hA4, exp_we: 1'b0, exp_addr: 4'd0};
        vecs[4] = '{pt: 1'b1, de: 1'b1, pix: 8'hA5, exp_we: 1'b1, exp_addr: 4'd1};
        vecs[5] = '{pt: 1'b0, de: 1'b1, pix: 8'hA6, exp_we: 1'b0, exp_addr: 4'd1};

        rstn = 1'b0; en = 1'b0; cont = 1'b0; p_tick = 1'b0; vsync = 1'b1; de = 1'b0; pix = '0;
        tick(3);
        check("rst_we",   32'(we_o),   0);
        check("rst_en",   32'(en_o),   0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_ovr",  32'(ovr_o),  0);
        check("rst_und",  32'(und_o),  0);
        check("rst_addr", 32'(addr_o), 0);
        check("rst_data", 32'(data_o), 0);
        rstn = 1'b1;
        tick(2);

        // Single-shot frame of exactly RAM_DEPTH pixels.
        clear_log();
        arm();
        check("t1_busy_armed", 32'(busy_o), 1);
        check("t1_en_armed",   32'(en_o),   1);
        vs_edge();
        send_pixels(8'h10, 16);
        vs_edge();
        check("t1_writes", wr_addr.size(), 16);
        check_frame("t1", 0, 8'h10, 16);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_busy_idle", 32'(busy_o), 0);
        check("t1_en_idle",   32'(en_o),   0);
        check("t1_ovr", 32'(ovr_o), 0);
        check("t1_und", 32'(und_o), 0);
        check("t1_ram15", 32'(ram[15]), 32'h1F);

        // Arm partway through frame A: only frame B is captured.
        clear_log();
        vs_edge();
        send_pixels(8'h30, 6);
        arm();
        send_pixels(8'h36, 10);
        check("t2_no_partial", wr_addr.size(), 0);
        vs_edge();
        send_pixels(8'h40, 16);
        vs_edge();
        check("t2_writes", wr_addr.size(), 16);
        check_frame("t2", 0, 8'h40, 16);
        check("t2_done_cnt", done_cnt, 1);

        // Overrun: 20 pixels, the last 4 dropped; flag persists in IDLE.
        clear_log();
        arm();
        vs_edge();
        send_pixels(8'h20, 20);
        check("t3_ovr_mid", 32'(ovr_o), 1);
        vs_edge();
        check("t3_writes", wr_addr.size(), 16);
        check_frame("t3", 0, 8'h20, 16);
        check("t3_und", 32'(und_o), 0);
        tick(10);
        check("t3_ovr_sticky", 32'(ovr_o), 1);
        check("t3_busy_idle", 32'(busy_o), 0);

        // Continuous: short frame then full frame.
        clear_log();
        cont = 1'b1;
        arm();
        check("t4_ovr_cleared", 32'(ovr_o), 0);
        vs_edge();
        send_pixels(8'h60, 10);
        vs_edge();
        check("t4_done_first", done_cnt, 1);
        check("t4_und", 32'(und_o), 1);
        check("t4_busy_cont", 32'(busy_o), 1);
        send_pixels(8'h70, 16);
        cont = 1'b0;
        vs_edge();
        check("t4_done_cnt", done_cnt, 2);
        check("t4_writes", wr_addr.size(), 26);
        check_frame("t4a", 0, 8'h60, 10);
        check_frame("t4b", 10, 8'h70, 16);
        check("t4_busy_idle", 32'(busy_o), 0);
        check("t4_ovr", 32'(ovr_o), 0);

        // Reset after the 5th pixel of a frame.
        clear_log();
        arm();
        vs_edge();
        send_pixels(8'h80, 5);
        check("t5_writes_pre", wr_addr.size(), 5);
        rstn = 1'b0;
        tick();
        check("t5_we",   32'(we_o),   0);
        check("t5_en",   32'(en_o),   0);
        check("t5_busy", 32'(busy_o), 0);
        check("t5_addr", 32'(addr_o), 0);
        check("t5_data", 32'(data_o), 0);
        check("t5_und",  32'(und_o),  0);
        send_pixels(8'h85, 2);
        rstn = 1'b1;
        send_pixels(8'h87, 4);
        vs_edge();
        send_pixels(8'h90, 4);
        check("t5_writes_post", wr_addr.size(), 5);
        check("t5_done", done_cnt, 0);
        check("t5_idle", 32'(busy_o), 0);

        // Pixel qualification: only p_tick & de produce a write.
        clear_log();
        arm();
        vs_edge();
        foreach (vecs[i]) begin
            p_tick = vecs[i].pt; de = vecs[i].de; pix = vecs[i].pix;
            tick();
            p_tick = 1'b0; de = 1'b0;
            check($sformatf("t6_v%0d_we", i),   32'(we_o),   32'(vecs[i].exp_we));
            check($sformatf("t6_v%0d_addr", i), 32'(addr_o), 32'(vecs[i].exp_addr));
            if (vecs[i].exp_we) check($sformatf("t6_v%0d_data", i), 32'(data_o), 32'(vecs[i].pix));
            tick(3);
        end
        check("t6_writes", wr_addr.size(), 2);
        vs_edge();
        check("t6_und", 32'(und_o), 1);
        check("t6_done", done_cnt, 1);

        check("we_back_to_back", bb_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
